zap_rori_encoder: RTL and testbench

Multi-cycle rotated-immediate encoder; the inverse of the barrel shifter's RORI operation. Given a 32-bit constant, it searches for an 8-bit immediate `imm8` and a 4-bit rotate field `rot` such that `value == ROR(imm8, 2*rot)`. It sits beside the decode/shift path and serves the instruction-rewrite and self-test logic. It uses valid/ready handshakes on both sides and evaluates one rotation per cycle.

---
 rtl/zap_rori_encoder.sv | 146 ++++++++++++++
 tb/tb_zap_rori_encoder.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/zap_rori_encoder.sv
// ============================================================================
// Module   : zap_rori_encoder
// Purpose  : Multi-cycle rotated-immediate encoder, the inverse of the barrel
//            shifter's RORI operation. Finds imm8/rot such that
//            value == ROR(imm8, 2*rot), testing one rotation per cycle and
//            returning the smallest matching rotation.
// Ports    : i_clk, i_reset_n (async, active-low)
//            i_valid / o_ready / i_value      : request handshake + operand
//            o_valid / i_ready                : result handshake
//            o_found, o_imm8, o_rot, o_neg    : result fields
// Options  : ZAP_RORI_ENC_NEG_EN - also search the inverted value (MVN/BIC
//            form); o_neg flags that form. Undefined: o_neg tied to 0.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module zap_rori_encoder (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_valid,
  input  logic [31:0] i_value,
  output logic        o_ready,
  output logic        o_valid,
  input  logic        i_ready,
  output logic        o_found,
  output logic [7:0]  o_imm8,
  output logic [3:0]  o_rot,
  output logic        o_neg
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  localparam logic [3:0] C_LAST_ROT = 4'd15;

  state_e      state_q;
  logic [31:0] val_q;      // captured operand
  logic [3:0]  rot_q;      // rotation currently under test
  logic        found_q;
  logic [7:0]  imm_q;
  logic [3:0]  rot_res_q;

  // Left-rotate by an even amount. For a zero amount the right shift is by
  // 32, which yields 0, so the result is simply x.
  function automatic logic [31:0] rol_even(input logic [31:0] x,
                                           input logic [3:0]  r);
    logic [5:0] sh;
    sh = {1'b0, r, 1'b0};
    return (x << sh) | (x >> (6'd32 - sh));
  endfunction

  // Positive form: ROL(val, 2r) fits in 8 bits  <=>  val == ROR(imm8, 2r).
  logic [31:0] w_pos_rol;
  logic        w_pos_hit;
  assign w_pos_rol = rol_even(val_q, rot_q);
  assign w_pos_hit = (w_pos_rol[31:8] == 24'd0);

`ifdef ZAP_RORI_ENC_NEG_EN
  logic        neg_q;
  logic [31:0] w_neg_rol;
  logic        w_neg_hit;
  assign w_neg_rol = rol_even(~val_q, rot_q);
  assign w_neg_hit = (w_neg_rol[31:8] == 24'd0);
  assign o_neg     = neg_q;
`else
  assign o_neg     = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q   <= ST_IDLE;
      val_q     <= 32'd0;
      rot_q     <= 4'd0;
      found_q   <= 1'b0;
      imm_q     <= 8'd0;
      rot_res_q <= 4'd0;
`ifdef ZAP_RORI_ENC_NEG_EN
      neg_q     <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (i_valid) begin
            val_q   <= i_value;
            rot_q   <= 4'd0;
            state_q <= ST_SEARCH;
          end
        end

        ST_SEARCH: begin
          // Positive form is checked first so it wins ties at the same r.
          if (w_pos_hit) begin
            found_q   <= 1'b1;
            imm_q     <= w_pos_rol[7:0];
            rot_res_q <= rot_q;
`ifdef ZAP_RORI_ENC_NEG_EN
            neg_q     <= 1'b0;
`endif
            state_q   <= ST_DONE;
`ifdef ZAP_RORI_ENC_NEG_EN
          end else if (w_neg_hit) begin
            found_q   <= 1'b1;
            imm_q     <= w_neg_rol[7:0];
            rot_res_q <= rot_q;
            neg_q     <= 1'b1;
            state_q   <= ST_DONE;
`endif
          end else if (rot_q == C_LAST_ROT) begin
            found_q   <= 1'b0;
            imm_q     <= 8'd0;
            rot_res_q <= 4'd0;
`ifdef ZAP_RORI_ENC_NEG_EN
            neg_q     <= 1'b0;
`endif
            state_q   <= ST_DONE;
          end else begin
            rot_q <= rot_q + 4'd1;
          end
        end

        ST_DONE: begin
          if (i_ready) begin
            state_q <= ST_IDLE;
          end
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Handshake outputs decode straight from state: no input-to-output paths.
  assign o_ready = (state_q == ST_IDLE);
  assign o_valid = (state_q == ST_DONE);
  assign o_found = found_q;
  assign o_imm8  = imm_q;
  assign o_rot   = rot_res_q;

endmodule

`default_nettype wire

// File: tb/tb_zap_rori_encoder.sv
// ============================================================================
// Module   : tb_zap_rori_encoder
// Purpose  : Self-checking bench for zap_rori_encoder. Directed table of
//            vectors, hand sequences for backpressure and mid-search reset,
//            and random operands checked against a brute-force model that
//            enumerates every (imm8, rot) pair.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_zap_rori_encoder;

  logic        clk;
  logic        rst_n;
  logic        i_valid;
  logic [31:0] i_value;
  logic        o_ready;
  logic        o_valid;
  logic        i_ready;
  logic        o_found;
  logic [7:0]  o_imm8;
  logic [3:0]  o_rot;
  logic        o_neg;

  int n_checks = 0;
  int n_fail   = 0;

  zap_rori_encoder dut (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .i_valid   (i_valid),
    .i_value   (i_value),
    .o_ready   (o_ready),
    .o_valid   (o_valid),
    .i_ready   (i_ready),
    .o_found   (o_found),
    .o_imm8    (o_imm8),
    .o_rot     (o_rot),
    .o_neg     (o_neg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] value;
    logic        found;
    logic [7:0]  imm;
    logic [3:0]  rot;
    logic        neg;
    int          lat;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] ror32(input logic [31:0] x, input int n);
    logic [63:0] t;
    t = {x, x} >> n;
    return t[31:0];
  endfunction

  // Reference: enumerate every immediate at each rotation, smallest rotation
  // first; at one rotation the positive form beats the inverted one.
  task automatic ref_enc(input logic [31:0] v, output logic found,
                         output logic [7:0] imm, output logic [3:0] rot,
                         output logic neg, output int lat);
    bit neg_en;
`ifdef ZAP_RORI_ENC_NEG_EN
    neg_en = 1'b1;
`else
    neg_en = 1'b0;
`endif
    found = 0; imm = 0; rot = 0; neg = 0; lat = 16;
    for (int r = 0; r < 16 && !found; r++) begin
      for (int k = 0; k < 256 && !found; k++)
        if (ror32(32'(k), 2 * r) == v) begin
          found = 1; imm = 8'(k); rot = 4'(r); lat = r + 1;
        end
      for (int k = 0; k < 256 && !found && neg_en; k++)
        if (ror32(32'(k), 2 * r) == ~v) begin
          found = 1; imm = 8'(k); rot = 4'(r); neg = 1; lat = r + 1;
        end
    end
  endtask

  // One full transaction: accept, measure latency, check result, optionally
  // hold backpressure for 'hold' cycles and poke i_valid while busy.
  task automatic run_req(input logic [31:0] v, input logic e_found,
                         input logic [7:0] e_imm, input logic [3:0] e_rot,
                         input logic e_neg, input int e_lat,
                         input int hold, input bit poke);
    int g;
    int cyc;
    g = 0;
    while (!o_ready && g < 50) begin
      @(posedge clk); #1; g++;
    end
    if (!o_ready) begin
      chk("ready_timeout", 32'(o_ready), 32'd1);
      return;
    end
    i_ready = (hold == 0);
    i_value = v;
    i_valid = 1'b1;
    @(posedge clk); #1;
    i_valid = poke;
    i_value = $urandom;          // operand must have been captured already
    chk("ready_busy", 32'(o_ready), 32'd0);
    cyc = 0;
    do begin
      @(posedge clk); #1; cyc++;
    end while (!o_valid && cyc < 40);
    if (!o_valid) begin
      chk("valid_timeout", 32'(o_valid), 32'd1);
      i_valid = 1'b0;
      return;
    end
    chk($sformatf("latency[%h]", v), 32'(cyc), 32'(e_lat));
    chk($sformatf("found[%h]", v), 32'(o_found), 32'(e_found));
    chk($sformatf("imm8[%h]", v), 32'(o_imm8), 32'(e_imm));
    chk($sformatf("rot[%h]", v), 32'(o_rot), 32'(e_rot));
    chk($sformatf("neg[%h]", v), 32'(o_neg), 32'(e_neg));
    chk("ready_in_done", 32'(o_ready), 32'd0);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      chk("bp_valid", 32'(o_valid), 32'd1);
      chk("bp_ready", 32'(o_ready), 32'd0);
      chk("bp_result", {19'd0, o_found, o_imm8, o_rot},
          {19'd0, e_found, e_imm, e_rot});
    end
    i_ready = 1'b1;
    @(posedge clk); #1;           // handshake edge
    i_valid = 1'b0;
    chk("post_hs_valid", 32'(o_valid), 32'd0);
    chk("post_hs_ready", 32'(o_ready), 32'd1);
    if (poke) begin
      repeat (2) @(posedge clk);
      #1;
      chk("no_second_result", 32'(o_valid), 32'd0);
    end
  endtask

  task automatic run_model(input logic [31:0] v, input int hold,
                           input bit poke);
    logic f, n;
    logic [7:0] im;
    logic [3:0] ro;
    int l;
    ref_enc(v, f, im, ro, n, l);
    run_req(v, f, im, ro, n, l, hold, poke);
  endtask

  initial begin
    i_valid = 1'b0;
    i_value = 32'd0;
    i_ready = 1'b1;
    rst_n   = 1'b0;

    tbl[0] = '{32'h000000FF, 1'b1, 8'hFF, 4'd0,  1'b0, 1};
    tbl[1] = '{32'hFF000000, 1'b1, 8'hFF, 4'd4,  1'b0, 5};
    tbl[2] = '{32'hF000000F, 1'b1, 8'hFF, 4'd2,  1'b0, 3};
    tbl[3] = '{32'h00000101, 1'b0, 8'h00, 4'd0,  1'b0, 16};
    tbl[4] = '{32'h00000000, 1'b1, 8'h00, 4'd0,  1'b0, 1};
`ifdef ZAP_RORI_ENC_NEG_EN
    tbl[5] = '{32'hFFFFFF00, 1'b1, 8'hFF, 4'd0,  1'b1, 1};
`else
    tbl[5] = '{32'hFFFFFF00, 1'b0, 8'h00, 4'd0,  1'b0, 16};
`endif
    tbl[6] = '{32'h000003FC, 1'b1, 8'hFF, 4'd15, 1'b0, 16};
    tbl[7] = '{32'h80000001, 1'b1, 8'h06, 4'd1,  1'b0, 2};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 32'(o_ready), 32'd1);
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_result", {19'd0, o_found, o_imm8, o_rot, o_neg}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++)
      run_req(tbl[i].value, tbl[i].found, tbl[i].imm, tbl[i].rot,
              tbl[i].neg, tbl[i].lat, 0, 1'b0);

    // Backpressure with a competing request during SEARCH/DONE.
    run_req(32'hF000000F, 1'b1, 8'hFF, 4'd2, 1'b0, 3, 5, 1'b1);

    // Leave a non-zero result on the outputs, then reset mid-search.
    run_req(32'h000000FF, 1'b1, 8'hFF, 4'd0, 1'b0, 1, 0, 1'b0);
    i_value = 32'h00000101;
    i_valid = 1'b1;
    @(posedge clk); #1;
    i_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_ready", 32'(o_ready), 32'd1);
    chk("midrst_valid", 32'(o_valid), 32'd0);
    chk("midrst_result", {19'd0, o_found, o_imm8, o_rot, o_neg}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("after_rst_ready", 32'(o_ready), 32'd1);
    run_req(32'h000000FF, 1'b1, 8'hFF, 4'd0, 1'b0, 1, 0, 1'b0);

    // Random operands: encodable, inverted-encodable, arbitrary, sparse.
    for (int i = 0; i < 40; i++) begin
      logic [31:0] v;
      int sel;
      sel = $urandom_range(0, 3);
      v = ror32(32'($urandom_range(0, 255)), 2 * $urandom_range(0, 15));
      if (sel == 1) v = ~v;
      if (sel == 2) v = $urandom;
      if (sel == 3) v = (32'd1 << $urandom_range(0, 31)) |
                        (32'd1 << $urandom_range(0, 31));
      run_model(v, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
